// File: rtl/fifo_stat_if.sv
// Handshake bundle between a fifo_stat instance and its user.
// The master side pushes/pulls; the slave side is the FIFO itself.
interface fifo_stat_if #(
    parameter int g_width = 32,
    parameter int g_depth = 16
);
    localparam int c_cnt_width = $clog2(g_depth + 1);

    logic [g_width-1:0]     data_i;
    logic                   push_i;
    logic                   pull_i;
    logic                   clr_err_i;
    logic [g_width-1:0]     data_o;
    logic [c_cnt_width-1:0] count_o;
    logic                   full_o;
    logic                   empty_o;
    logic                   afull_o;
    logic                   aempty_o;
    logic                   ovf_o;
    logic                   udf_o;

    modport master (
        output data_i, push_i, pull_i, clr_err_i,
        input  data_o, count_o, full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o
    );

    modport slave (
        input  data_i, push_i, pull_i, clr_err_i,
        output data_o, count_o, full_o, empty_o, afull_o, aempty_o, ovf_o, udf_o
    );
endinterface

// File: rtl/fifo_stat.sv
// Synchronous show-ahead FIFO of arbitrary depth with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module fifo_stat #(
    parameter int g_width  = 32,
    parameter int g_depth  = 16,
    parameter int g_afull  = g_depth - 2,
    parameter int g_aempty = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    fifo_stat_if.slave  bus
);
    localparam int c_cnt_width = $clog2(g_depth + 1);
    localparam int c_ptr_width = (g_depth <= 2) ? 1 : $clog2(g_depth);

    localparam logic [c_ptr_width-1:0] c_ptr_last  = c_ptr_width'(g_depth - 1);
    localparam logic [c_cnt_width-1:0] c_cnt_full  = c_cnt_width'(g_depth);
    localparam logic [c_cnt_width-1:0] c_cnt_afull = c_cnt_width'(g_afull);
    localparam logic [c_cnt_width-1:0] c_cnt_aempt = c_cnt_width'(g_aempty);

    logic [g_width-1:0]     r_mem [g_depth];
    logic [c_ptr_width-1:0] r_wr_ptr;
    logic [c_ptr_width-1:0] r_rd_ptr;
    logic [c_cnt_width-1:0] r_count;
    logic                   r_full;
    logic                   r_empty;
    logic                   r_afull;
    logic                   r_aempty;
    logic                   r_ovf;
    logic                   r_udf;

    logic                   w_push_acc;
    logic                   w_pull_acc;
    logic [c_ptr_width-1:0] w_wr_ptr_next;
    logic [c_ptr_width-1:0] w_rd_ptr_next;
    logic [c_cnt_width-1:0] w_count_next;

    // A full FIFO still accepts a push when a pull frees the head slot in the same cycle.
    always_comb begin
        w_push_acc = bus.push_i & (~r_full | bus.pull_i);
        w_pull_acc = bus.pull_i & ~r_empty;
    end

    // Pointers wrap by explicit compare so any depth works, not just powers of two.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (w_push_acc) begin
            w_wr_ptr_next = (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + c_ptr_width'(1);
        end
        if (w_pull_acc) begin
            w_rd_ptr_next = (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + c_ptr_width'(1);
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push_acc && !w_pull_acc) begin
            w_count_next = r_count + c_cnt_width'(1);
        end else if (w_pull_acc && !w_push_acc) begin
            w_count_next = r_count - c_cnt_width'(1);
        end
    end

    // Storage is never reset; reset only discards it logically via the pointers.
    always_ff @(posedge clk_i) begin
        if (w_push_acc && !rst_i) begin
            r_mem[r_wr_ptr] <= bus.data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            // Flags are derived from the next count so they always agree with count_o.
            r_full   <= (w_count_next == c_cnt_full);
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= c_cnt_afull);
            r_aempty <= (w_count_next <= c_cnt_aempt);
        end
    end

    // A new error in the same cycle as clr_err_i keeps the flag set.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (bus.push_i & ~w_push_acc) | (r_ovf & ~bus.clr_err_i);
            r_udf <= (bus.pull_i & ~w_pull_acc) | (r_udf & ~bus.clr_err_i);
        end
    end

    assign bus.data_o   = r_mem[r_rd_ptr];
    assign bus.count_o  = r_count;
    assign bus.full_o   = r_full;
    assign bus.empty_o  = r_empty;
    assign bus.afull_o  = r_afull;
    assign bus.aempty_o = r_aempty;
    assign bus.ovf_o    = r_ovf;
    assign bus.udf_o    = r_udf;
endmodule

// File: doc/fifo_stat.md
# fifo_stat

Parametrised synchronous FIFO with show-ahead read, occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the next-generation buffer for the SPI and AXI data paths: the TX/RX queues between the AXI register front-end and the SPI shifter. Depth is no longer restricted to a power of two. Status is derived from a single registered occupancy counter rather than a guard bit, so the count is directly readable through a register.

## Interface
- g_width, 32, data word width in bits (≥1)
- g_depth, 16, number of storage words (≥2, any integer; not required to be a power of two)
- g_afull, g_depth-2, afull_o asserted when count ≥ g_afull (1..g_depth)
- g_aempty, 1, aempty_o asserted when count ≤ g_aempty (0..g_depth-1)
- c_cnt_width (local), clog2(g_depth+1), width of count_o
- c_ptr_width (local), max(1, clog2(g_depth)), pointer width

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- data_i  in  g_width  write data, sampled with push_i
- push_i  in  1  write request
- pull_i  in  1  read request; pops the word currently on data_o
- clr_err_i  in  1  clears ovf_o/udf_o
- data_o  out  g_width  head word (show-ahead), valid only while empty_o=0
- count_o  out  c_cnt_width  current occupancy, 0..g_depth
- full_o  out  1  count_o == g_depth
- empty_o  out  1  count_o == 0
- afull_o  out  1  count_o ≥ g_afull
- aempty_o  out  1  count_o ≤ g_aempty
- ovf_o  out  1  sticky: a push was dropped
- udf_o  out  1  sticky: a pull was ignored

## Operation
- Storage: g_depth × g_width array, written on the clock edge at wr_ptr. Not reset. Contents are undefined until written.
- Pointers: wr_ptr and rd_ptr count 0..g_depth-1. Each wraps to 0 when incremented from g_depth-1; this is an explicit compare, not a binary overflow.
- Accepted write: push_acc = push_i & (!full_o | pull_i).
  - When full, a simultaneous push and pull are both accepted.
- Accepted read: pull_acc = pull_i & !empty_o.
  - When empty, a simultaneous push and pull: the push is accepted and the pull is ignored.
- Updates on every clock edge:
  - push_acc: write mem[wr_ptr] ← data_i; advance wr_ptr.
  - pull_acc: advance rd_ptr.
  - count: +1 if push_acc & !pull_acc; −1 if pull_acc & !push_acc; otherwise unchanged.
- Status flags are registered. Each is recomputed from the next count value, so every flag is consistent with count_o in the same cycle.
- Error flags:
  - ovf_o set when push_i & !push_acc.
  - udf_o set when pull_i & !pull_acc.
  - clr_err_i clears both; a set condition in the same cycle wins over the clear.
- data_o = mem[rd_ptr], combinational from the array and rd_ptr.
- Reset (rst_i high at an edge), regardless of push/pull:
  - wr_ptr=0, rd_ptr=0, count_o=0
  - empty_o=1, full_o=0, afull_o=0, aempty_o=1, ovf_o=0, udf_o=0
  - Array contents are retained but logically discarded.
  - Reset mid-burst drops all stored words; the first push after reset lands at index 0.

## Timing
- Write-to-read latency is 1 cycle: push accepted at edge N → empty_o=0 and data_o = that word after edge N.
- Pull at edge N → data_o shows the next word after edge N. No read-data register.
- Flags and count change only on clock edges, one edge after the causing request.
- Throughput: one push and one pull per cycle sustained at any occupancy 1..g_depth-1. At g_depth the same holds if push and pull coincide.
- Combinational paths:
  - data_o depends only on array and rd_ptr.
  - push_acc and pull_acc depend on inputs and registered flags.
  - No input-to-output combinational path.

## Test plan
- Reset and basic order (g_depth=5, g_width=8): push 0x11..0x15 on consecutive cycles.
  - count_o steps 1..5; full_o=1 after the 5th edge; afull_o=1 from count 3.
  - Pull 5 → data_o sequence 0x11..0x15; empty_o=1 after the last pull.
- Non-power-of-two wrap (g_depth=5): 12 push/pull pairs at count 2.
  - Pointers wrap through 4→0.
  - Data order preserved; count_o stays 2 throughout.
- Overflow: with full_o=1, push 0xAA alone.
  - Word dropped; count_o stays 5; ovf_o=1 next cycle and stays 1.
  - Pulsing clr_err_i → ovf_o=0 next cycle.
- Full simultaneous and empty simultaneous:
  - At full, push 0xBB + pull → count stays 5; head advances; 0xBB is read last; ovf_o=0.
  - At empty, push 0xCC + pull → count_o=1; data_o=0xCC; udf_o=1.
- Clear versus set: pull_i while empty together with clr_err_i → udf_o=1.
- Reset mid-operation: with count_o=3, assert rst_i one cycle together with push_i.
  - All outputs take their reset values; count_o=0; the push is ignored.
  - The next push is read back correctly.
